// File: rtl/alu_result_fifo_if.sv
// Valid/ready handshake bundle between the ALU, the result FIFO and the writeback consumer.
// The slave modport is the FIFO side; the master modport is the ALU/consumer (or bench) side.
interface alu_result_fifo_if #(
  parameter int N     = 8,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N-1:0]             in_result;
  logic [3:0]               in_op;
  logic                     out_valid;
  logic                     out_ready;
  logic [N-1:0]             out_result;
  logic [3:0]               out_op;
  logic                     out_illegal;
  logic                     out_zero;
  logic                     out_neg;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_result, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_op, out_illegal, out_zero, out_neg, count
  );

  modport slave (
    input  in_valid, in_result, in_op, out_ready,
    output in_ready, out_valid, out_result, out_op, out_illegal, out_zero, out_neg, count
  );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO buffering ALU results with their opcode tag.
// Optional feature macro: ALU_FLAGS_EN stores zero/neg flags per entry.
module alu_result_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu_result_fifo_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [N-1:0]  mem_result  [DEPTH];
  logic [3:0]    mem_op      [DEPTH];
  logic          mem_illegal [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop;

  // Full/empty come from the occupancy counter, so pointers may wrap freely.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = bus.in_valid & ~full;
  assign pop   = bus.out_ready & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr_q]  <= bus.in_result;
      mem_op[wr_ptr_q]      <= bus.in_op;
      mem_illegal[wr_ptr_q] <= (bus.in_op > 4'd8);
    end
  end

  assign bus.in_ready    = ~full;
  assign bus.out_valid   = ~empty;
  assign bus.count       = count_q;
  assign bus.out_result  = empty ? '0   : mem_result[rd_ptr_q];
  assign bus.out_op      = empty ? 4'd0 : mem_op[rd_ptr_q];
  assign bus.out_illegal = empty ? 1'b0 : mem_illegal[rd_ptr_q];

`ifdef ALU_FLAGS_EN
  logic mem_zero [DEPTH];
  logic mem_neg  [DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_zero[wr_ptr_q] <= (bus.in_result == '0);
      mem_neg[wr_ptr_q]  <= bus.in_result[N-1];
    end
  end

  assign bus.out_zero = empty ? 1'b0 : mem_zero[rd_ptr_q];
  assign bus.out_neg  = empty ? 1'b0 : mem_neg[rd_ptr_q];
`else
  assign bus.out_zero = 1'b0;
  assign bus.out_neg  = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: queue-based reference model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_alu_result_fifo;
  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_result_fifo_if #(.N(N), .DEPTH(DEPTH)) bus ();

  alu_result_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] res;
    logic [3:0]   op;
  } ent_t;

  ent_t mq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain queue, accept when not full, release head when not empty.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      bit do_push, do_pop;
      ent_t e;
      do_push = bus.in_valid && (mq.size() < DEPTH);
      do_pop  = bus.out_ready && (mq.size() > 0);
      e.res = bus.in_result;
      e.op  = bus.in_op;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] h_res;
    logic [3:0]   h_op;
    bit           nonempty;
    nonempty = (mq.size() > 0);
    h_res = nonempty ? mq[0].res : '0;
    h_op  = nonempty ? mq[0].op  : 4'd0;
    check("m_count",   32'(bus.count),     32'(mq.size()));
    check("m_valid",   32'(bus.out_valid), 32'(nonempty));
    check("m_ready",   32'(bus.in_ready),  32'(mq.size() < DEPTH));
    check("m_result",  32'(bus.out_result), 32'(h_res));
    check("m_op",      32'(bus.out_op),    32'(h_op));
    check("m_illegal", 32'(bus.out_illegal), 32'(nonempty && (h_op > 4'd8)));
`ifdef ALU_FLAGS_EN
    check("m_zero", 32'(bus.out_zero), 32'(nonempty && (h_res == '0)));
    check("m_neg",  32'(bus.out_neg),  32'(nonempty && h_res[N-1]));
`else
    check("m_zero", 32'(bus.out_zero), 32'(0));
    check("m_neg",  32'(bus.out_neg),  32'(0));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [N-1:0] r, input logic [3:0] o);
    bus.in_valid  = 1'b1;
    bus.in_result = r;
    bus.in_op     = o;
    step();
    bus.in_valid  = 1'b0;
  endtask

  task automatic pop_expect(input string nm, input logic [N-1:0] r, input logic [3:0] o);
    bus.out_ready = 1'b1;
    check({nm, "_res"}, 32'(bus.out_result), 32'(r));
    check({nm, "_op"},  32'(bus.out_op),     32'(o));
    step();
    bus.out_ready = 1'b0;
  endtask

  logic [N-1:0] v2_res [4];
  logic [3:0]   v2_op  [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_result = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    #12 rst_n = 1'b1;
    step();

    // 1: idle after reset
    check("t1_in_ready",  32'(bus.in_ready),   32'd1);
    check("t1_out_valid", 32'(bus.out_valid),  32'd0);
    check("t1_count",     32'(bus.count),      32'd0);
    check("t1_out_res",   32'(bus.out_result), 32'd0);

    // 2: fill then drain in order
    v2_res[0] = 8'h12; v2_op[0] = 4'd0;
    v2_res[1] = 8'h2D; v2_op[1] = 4'd2;
    v2_res[2] = 8'h05; v2_op[2] = 4'd3;
    v2_res[3] = 8'hFF; v2_op[3] = 4'd8;
    push_one(v2_res[0], v2_op[0]);
    check("t2_fwft_valid", 32'(bus.out_valid),  32'd1);
    check("t2_fwft_res",   32'(bus.out_result), 32'h12);
    for (int i = 1; i < 4; i++) push_one(v2_res[i], v2_op[i]);
    check("t2_count_full", 32'(bus.count),    32'd4);
    check("t2_in_ready",   32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 4; i++) pop_expect("t2_pop", v2_res[i], v2_op[i]);
    check("t2_empty", 32'(bus.out_valid), 32'd0);

    // 3: full with simultaneous pop and push: no pass-through
    for (int i = 1; i <= 4; i++) push_one(8'(i), 4'(i - 1));
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_result = 8'h33;
    bus.in_op     = 4'd4;
    step();
    check("t3_count_after_pop", 32'(bus.count),      32'd3);
    check("t3_head",            32'(bus.out_result), 32'h02);
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    check("t3_count_refill", 32'(bus.count), 32'd4);
    pop_expect("t3_pop0", 8'h02, 4'd1);
    pop_expect("t3_pop1", 8'h03, 4'd2);
    pop_expect("t3_pop2", 8'h04, 4'd3);
    pop_expect("t3_pop3", 8'h33, 4'd4);

    // 4: steady stream at count=2
    push_one(8'h40, 4'd0);
    push_one(8'h41, 4'd1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_result = 8'(8'h42 + i);
      bus.in_op     = 4'((i + 2) % 9);
      check("t4_stream_head", 32'(bus.out_result), 32'(8'h40 + i));
      step();
      check("t4_count", 32'(bus.count), 32'd2);
    end
    bus.in_valid = 1'b0;
    check("t4_head_after", 32'(bus.out_result), 32'h4A);
    step();
    step();
    bus.out_ready = 1'b0;
    check("t4_drained", 32'(bus.count), 32'd0);

    // 5: flags and illegal opcode
    push_one(8'h80, 4'd1);
    push_one(8'h00, 4'd4);
    push_one(8'h07, 4'd9);
`ifdef ALU_FLAGS_EN
    check("t5_neg0",  32'(bus.out_neg),  32'd1);
    check("t5_zero0", 32'(bus.out_zero), 32'd0);
`else
    check("t5_neg0",  32'(bus.out_neg),  32'd0);
    check("t5_zero0", 32'(bus.out_zero), 32'd0);
`endif
    check("t5_ill0", 32'(bus.out_illegal), 32'd0);
    pop_expect("t5_pop0", 8'h80, 4'd1);
`ifdef ALU_FLAGS_EN
    check("t5_zero1", 32'(bus.out_zero), 32'd1);
`else
    check("t5_zero1", 32'(bus.out_zero), 32'd0);
`endif
    check("t5_neg1", 32'(bus.out_neg), 32'd0);
    pop_expect("t5_pop1", 8'h00, 4'd4);
    check("t5_ill2", 32'(bus.out_illegal), 32'd1);
    check("t5_op2",  32'(bus.out_op),      32'd9);
    pop_expect("t5_pop2", 8'h07, 4'd9);

    // 6: asynchronous reset mid-operation
    push_one(8'hA1, 4'd0);
    push_one(8'hA2, 4'd1);
    push_one(8'hA3, 4'd2);
    check("t6_count3", 32'(bus.count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_count", 32'(bus.count),     32'd0);
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_res",   32'(bus.out_result), 32'd0);
    #4 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    step();
    check("t6_after_valid", 32'(bus.out_valid),  32'd0);
    check("t6_after_res",   32'(bus.out_result), 32'd0);
    bus.out_ready = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
